bios_boot_watchdog: RTL and testbench
=====================================

BIOS_BOOT_WATCHDOG -- requirements
Module: bios_boot_watchdog

Interface
REQ-001 Parameter CNT_W, default 20, boot-timer width in bits.
REQ-002 Parameter TIMEOUT, default 20'd983040, Clk cycles allowed from PciReset rise to BootDone (30 s at 32.768 kHz).
REQ-003 Parameter RST_PULSE, default 16, BiosRstReq pulse length in Clk cycles.
REQ-004 Parameter MAX_FAIL, default 2, consecutive timeouts before giving up (range 1..3).
REQ-005 Clk  input  1  single clock for all state.
REQ-006 Reset  input  1  reset, synchronous, active-high.
REQ-007 Pwr_ok  input  1  main power good; 0 means platform off.
REQ-008 PciReset  input  1  platform reset status; 1 = platform running, 0 = in reset.
REQ-009 BootDone  input  1  level, BIOS POST-complete indication.
REQ-010 WdtEnable  input  1  1 = boot timer armed; 0 = every boot treated as good.
REQ-011 SwSel_Valid  input  1  one-cycle strobe, software next-BIOS request.
REQ-012 SwSel_Bios  input  1  requested next BIOS (0/1), sampled with SwSel_Valid.
REQ-013 Active_Bios  output  1  BIOS selected now; drives downstream chip-select decode.
REQ-014 Next_Bios  output  1  BIOS to use after next platform reset.
REQ-015 BiosRstReq  output  1  platform-reset request pulse to power sequencer.
REQ-016 BootFail  output  1  sticky, all retries exhausted.
REQ-017 FailCnt  output  2  consecutive timeout count.
REQ-018 WdtState  output  3  FSM state encoding, debug.

Function
REQ-019 All inputs used synchronously; PciReset registered once (PciReset_d); rise = PciReset & ~PciReset_d, fall = ~PciReset & PciReset_d.
REQ-020 States: IDLE=0, WAIT_RUN=1, TIMING=2, BOOTED=3, SWITCH=4, FAILED=5; other codes SHALL return to IDLE next cycle.
REQ-021 Pwr_ok=0 in any state SHALL force IDLE next cycle, clear timer and BiosRstReq; Active_Bios, Next_Bios, FailCnt, BootFail retained.
REQ-022 IDLE: Pwr_ok=1 -> WAIT_RUN; on that transition Active_Bios <= Next_Bios, FailCnt <= 0, BootFail <= 0.
REQ-023 WAIT_RUN: rise with WdtEnable=1 -> TIMING, timer <= 0; rise with WdtEnable=0 -> BOOTED.
REQ-024 TIMING: timer increments by 1 per cycle, saturating at TIMEOUT-1; never wraps.
REQ-025 TIMING: BootDone=1 -> BOOTED, FailCnt <= 0; BootDone SHALL win over a same-cycle timeout.
REQ-026 TIMING: fall (host warm reset) -> WAIT_RUN, timer cleared, FailCnt unchanged; fall wins over timeout, BootDone wins over fall.
REQ-027 TIMING: timer==TIMEOUT-1 and BootDone=0 -> FailCnt+1; if FailCnt+1==MAX_FAIL -> FAILED, else SWITCH.
REQ-028 SWITCH entry cycle: Active_Bios <= ~Active_Bios and Next_Bios <= ~Active_Bios (same value).
REQ-029 SWITCH: BiosRstReq=1 for exactly RST_PULSE cycles starting the cycle after the timeout cycle, then WAIT_RUN with BiosRstReq=0.
REQ-030 BOOTED: fall -> WAIT_RUN with Active_Bios <= Next_Bios; FailCnt held at 0.
REQ-031 WAIT_RUN: a fall (reset re-entry) SHALL also load Active_Bios <= Next_Bios.
REQ-032 FAILED: BootFail=1, BiosRstReq=0, Active_Bios frozen; exit only via Pwr_ok=0 (to IDLE) or Reset.
REQ-033 SwSel_Valid=1 loads Next_Bios <= SwSel_Bios in all states except the SWITCH entry cycle, where REQ-028 wins; Active_Bios never changes directly from SwSel_Valid.
REQ-034 Active_Bios changes only at REQ-022, REQ-028, REQ-030, REQ-031 events.

Reset
REQ-035 Reset=1 SHALL set, next edge: state IDLE, timer 0, Active_Bios 0, Next_Bios 0, BiosRstReq 0, BootFail 0, FailCnt 0, PciReset_d 0.
REQ-036 Reset mid-SWITCH SHALL terminate the BiosRstReq pulse immediately.

Verification (TIMEOUT=100, RST_PULSE=4, MAX_FAIL=2)
REQ-037 Good boot: Pwr_ok=1, PciReset rise, BootDone at cycle 50 -> BOOTED, Active_Bios=0, FailCnt=0, BiosRstReq never 1.
REQ-038 Single failover: no BootDone -> at cycle 100 Active_Bios=1, Next_Bios=1, FailCnt=1, BiosRstReq high 4 cycles; second boot BootDone -> FailCnt=0, Active_Bios=1.
REQ-039 Double failure: no BootDone on two boots -> FAILED, BootFail=1, Active_Bios=1; Pwr_ok 0->1 -> BootFail=0, Active_Bios=Next_Bios=1.
REQ-040 Simultaneous: BootDone=1 on cycle 99 (timeout cycle) -> BOOTED, no toggle; fall on cycle 99 without BootDone -> WAIT_RUN, FailCnt=0.
REQ-041 Software select: in BOOTED, SwSel_Valid=1, SwSel_Bios=1 -> Next_Bios=1, Active_Bios stays 0 until PciReset fall, then 1.
REQ-042 Reset during SWITCH cycle 2 -> BiosRstReq=0 and all outputs at REQ-035 values next cycle.

Source files
------------

// File: rtl/bios_boot_watchdog_if.sv
// Platform-side signal bundle of the BIOS boot watchdog.
// The master side is the platform/power sequencer, the slave side is the watchdog.
interface bios_boot_watchdog_if;
   logic       Pwr_ok;
   logic       PciReset;
   logic       BootDone;
   logic       WdtEnable;
   logic       SwSel_Valid;
   logic       SwSel_Bios;
   logic       Active_Bios;
   logic       Next_Bios;
   logic       BiosRstReq;
   logic       BootFail;
   logic [1:0] FailCnt;
   logic [2:0] WdtState;

   modport master (
      output Pwr_ok, PciReset, BootDone, WdtEnable, SwSel_Valid, SwSel_Bios,
      input  Active_Bios, Next_Bios, BiosRstReq, BootFail, FailCnt, WdtState
   );

   modport slave (
      input  Pwr_ok, PciReset, BootDone, WdtEnable, SwSel_Valid, SwSel_Bios,
      output Active_Bios, Next_Bios, BiosRstReq, BootFail, FailCnt, WdtState
   );
endinterface

// File: rtl/bios_boot_watchdog.sv
// BIOS boot watchdog: times POST after each platform reset release, and on a
// timeout flips to the other BIOS image and requests a platform reset. After
// MAX_FAIL consecutive timeouts it gives up and flags BootFail until power cycles.
module bios_boot_watchdog #(
   parameter int unsigned      CNT_W     = 20,
   parameter logic [CNT_W-1:0] TIMEOUT   = 20'd983040,
   parameter int unsigned      RST_PULSE = 16,
   parameter int unsigned      MAX_FAIL  = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   bios_boot_watchdog_if.slave io_wdt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_RUN = 3'd1,
      S_TIMING   = 3'd2,
      S_BOOTED   = 3'd3,
      S_SWITCH   = 3'd4,
      S_FAILED   = 3'd5
   } state_e;

   localparam int unsigned      PW         = $clog2(RST_PULSE + 1);
   localparam logic [CNT_W-1:0] TIMER_MAX  = TIMEOUT - CNT_W'(1);
   localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE - 1);
   localparam logic [1:0]       MAX_FAIL_C = 2'(MAX_FAIL);

   state_e           r_state;
   state_e           w_state_next;
   logic [CNT_W-1:0] r_timer;
   logic [PW-1:0]    r_pulse_cnt;
   logic             r_pci_d;
   logic             r_active;
   logic             r_next;
   logic             r_boot_fail;
   logic [1:0]       r_fail_cnt;
   logic             w_rst_req;

   logic             w_rise;
   logic             w_fall;
   logic             w_timeout_hit;
   logic             w_give_up;
   logic [1:0]       w_fail_inc;
   logic             w_load_active;
   logic             w_clear_fail;

   // Edge detect on the registered platform-reset status.
   assign w_rise = io_wdt.PciReset & ~r_pci_d;
   assign w_fall = ~io_wdt.PciReset & r_pci_d;

   // A timeout only counts if neither BootDone nor a warm reset arrives in the same cycle.
   assign w_timeout_hit = io_wdt.Pwr_ok && (r_state == S_TIMING) && !io_wdt.BootDone
                          && !w_fall && (r_timer == TIMER_MAX);
   assign w_fail_inc    = r_fail_cnt + 2'd1;
   assign w_give_up     = (w_fail_inc == MAX_FAIL_C);

   // Active_Bios follows Next_Bios on power-up and on every platform reset entry.
   assign w_load_active = io_wdt.Pwr_ok &&
                          ((r_state == S_IDLE) ||
                           ((r_state == S_WAIT_RUN) && w_fall) ||
                           ((r_state == S_BOOTED) && w_fall));

   // Fail history is forgotten on power-up and on any successful boot.
   assign w_clear_fail  = io_wdt.Pwr_ok &&
                          ((r_state == S_IDLE) || (r_state == S_BOOTED) ||
                           ((r_state == S_TIMING) && io_wdt.BootDone));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; loss of power overrides everything.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_state_next = r_state;
      if (!io_wdt.Pwr_ok) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     w_state_next = S_WAIT_RUN;
            S_WAIT_RUN: if (w_rise) w_state_next = io_wdt.WdtEnable ? S_TIMING : S_BOOTED;
            S_TIMING: begin
               if (io_wdt.BootDone)   w_state_next = S_BOOTED;
               else if (w_fall)       w_state_next = S_WAIT_RUN;
               else if (w_timeout_hit) w_state_next = w_give_up ? S_FAILED : S_SWITCH;
            end
            S_BOOTED:   if (w_fall) w_state_next = S_WAIT_RUN;
            S_SWITCH:   if (r_pulse_cnt == PULSE_LAST) w_state_next = S_WAIT_RUN;
            S_FAILED:   w_state_next = S_FAILED;
            default:    w_state_next = S_IDLE;
         endcase
      end
   end

   // Output decode: the reset request is high for every cycle spent in SWITCH.
   always_comb begin
      w_rst_req = (r_state == S_SWITCH);
   end

   // Timers, edge register, BIOS selection and failure bookkeeping.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_timer     <= '0;
         r_pulse_cnt <= '0;
         r_pci_d     <= 1'b0;
         r_active    <= 1'b0;
         r_next      <= 1'b0;
         r_boot_fail <= 1'b0;
         r_fail_cnt  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
         r_pci_d <= io_wdt.PciReset;

         if ((r_state == S_TIMING) && (w_state_next == S_TIMING)) begin
            r_timer <= (r_timer == TIMER_MAX) ? r_timer : r_timer + CNT_W'(1);
         end else begin
            r_timer <= '0;
         end

         if ((r_state == S_SWITCH) && (w_state_next == S_SWITCH)) begin
            r_pulse_cnt <= r_pulse_cnt + PW'(1);
         end else begin
            r_pulse_cnt <= '0;
         end

         if (io_wdt.SwSel_Valid) begin
            r_next <= io_wdt.SwSel_Bios;
         end

         if (w_load_active) begin
            r_active <= r_next;
         end

         if (io_wdt.Pwr_ok && (r_state == S_IDLE)) begin
            r_boot_fail <= 1'b0;
         end

         if (w_clear_fail) begin
            r_fail_cnt <= 2'd0;
         end else if (w_timeout_hit) begin
            r_fail_cnt <= w_fail_inc;
         end

         // Failover toggles both selections; it overrides a same-cycle software request.
         if (w_timeout_hit && !w_give_up) begin
            r_active <= ~r_active;
            r_next   <= ~r_active;
         end

         if (w_timeout_hit && w_give_up) begin
            r_boot_fail <= 1'b1;
         end
      end
   end

   assign io_wdt.Active_Bios = r_active;
   assign io_wdt.Next_Bios   = r_next;
   assign io_wdt.BiosRstReq  = w_rst_req;
   assign io_wdt.BootFail    = r_boot_fail;
   assign io_wdt.FailCnt     = r_fail_cnt;
   assign io_wdt.WdtState    = r_state;

endmodule

// File: tb/tb_bios_boot_watchdog.sv
// Directed bench for bios_boot_watchdog with TIMEOUT=100, RST_PULSE=4, MAX_FAIL=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bios_boot_watchdog;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_TIMING = 3'd2;
   localparam logic [2:0] ST_BOOTED = 3'd3;
   localparam logic [2:0] ST_SWITCH = 3'd4;
   localparam logic [2:0] ST_FAILED = 3'd5;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   rq_cnt   = 0;
   int   rq_base  = 0;

   bios_boot_watchdog_if u_if ();

   bios_boot_watchdog #(
      .CNT_W     (20),
      .TIMEOUT   (20'd100),
      .RST_PULSE (4),
      .MAX_FAIL  (2)
   ) u_dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io_wdt  (u_if.slave)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count cycles in which the reset request is high.
   always @(negedge clk) begin
      if (u_if.BiosRstReq === 1'b1) rq_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against one expected set.
   task automatic check_all(input string tag, input logic [2:0] st, input logic act,
                            input logic nxt, input logic [1:0] fc, input logic bf,
                            input logic rq);
      check({tag, ".state"},  32'(u_if.WdtState),    32'(st));
      check({tag, ".active"}, 32'(u_if.Active_Bios), 32'(act));
      check({tag, ".next"},   32'(u_if.Next_Bios),   32'(nxt));
      check({tag, ".failcnt"},32'(u_if.FailCnt),     32'(fc));
      check({tag, ".bootfail"},32'(u_if.BootFail),   32'(bf));
      check({tag, ".rstreq"}, 32'(u_if.BiosRstReq),  32'(rq));
   endtask

   initial begin
      reset            = 1'b1;
      u_if.Pwr_ok      = 1'b0;
      u_if.PciReset    = 1'b0;
      u_if.BootDone    = 1'b0;
      u_if.WdtEnable   = 1'b1;
      u_if.SwSel_Valid = 1'b0;
      u_if.SwSel_Bios  = 1'b0;
      tick(2);
      check_all("reset", ST_IDLE, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;

      // Good boot: BootDone before the timeout.
      u_if.Pwr_ok = 1'b1;
      tick(1);
      check("good.wait", 32'(u_if.WdtState), 32'(ST_WAIT));
      u_if.PciReset = 1'b1;
      tick(1);
      check("good.timing", 32'(u_if.WdtState), 32'(ST_TIMING));
      tick(48);
      u_if.BootDone = 1'b1;
      tick(1);
      u_if.BootDone = 1'b0;
      check_all("good.booted", ST_BOOTED, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      check("good.no_pulse", 32'(rq_cnt), 32'd0);

      // Software select: Next changes now, Active only at the next reset entry.
      u_if.SwSel_Valid = 1'b1;
      u_if.SwSel_Bios  = 1'b1;
      tick(1);
      u_if.SwSel_Valid = 1'b0;
      check("swsel.next", 32'(u_if.Next_Bios), 32'd1);
      check("swsel.active_held", 32'(u_if.Active_Bios), 32'd0);
      u_if.PciReset = 1'b0;
      tick(1);
      check("swsel.fall_state", 32'(u_if.WdtState), 32'(ST_WAIT));
      check("swsel.fall_active", 32'(u_if.Active_Bios), 32'd1);

      // Select BIOS 0 again and power cycle so Active reloads from Next.
      u_if.SwSel_Valid = 1'b1;
      u_if.SwSel_Bios  = 1'b0;
      tick(1);
      u_if.SwSel_Valid = 1'b0;
      u_if.Pwr_ok = 1'b0;
      tick(1);
      check_all("pwroff", ST_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      u_if.Pwr_ok = 1'b1;
      tick(1);
      check_all("pwron", ST_WAIT, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Single failover.
      rq_base = rq_cnt;
      u_if.PciReset = 1'b1;
      tick(1);
      tick(99);
      check("fail1.last_timing", 32'(u_if.WdtState), 32'(ST_TIMING));
      check("fail1.not_toggled", 32'(u_if.Active_Bios), 32'd0);
      tick(1);
      check_all("fail1.switch", ST_SWITCH, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
      u_if.PciReset = 1'b0;
      tick(3);
      check("fail1.pulse_end", 32'(u_if.BiosRstReq), 32'd1);
      tick(1);
      check_all("fail1.wait", ST_WAIT, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
      check("fail1.pulse_len", 32'(rq_cnt - rq_base), 32'd4);
      u_if.PciReset = 1'b1;
      tick(1);
      tick(20);
      u_if.BootDone = 1'b1;
      tick(1);
      u_if.BootDone = 1'b0;
      check_all("fail1.reboot", ST_BOOTED, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

      // Double failure starting from BIOS 0.
      u_if.SwSel_Valid = 1'b1;
      u_if.SwSel_Bios  = 1'b0;
      tick(1);
      u_if.SwSel_Valid = 1'b0;
      u_if.PciReset = 1'b0;
      tick(1);
      check("dbl.start_active", 32'(u_if.Active_Bios), 32'd0);
      u_if.PciReset = 1'b1;
      tick(1);
      tick(100);
      check_all("dbl.switch", ST_SWITCH, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
      u_if.PciReset = 1'b0;
      tick(4);
      check("dbl.wait", 32'(u_if.WdtState), 32'(ST_WAIT));
      u_if.PciReset = 1'b1;
      tick(1);
      tick(100);
      check_all("dbl.failed", ST_FAILED, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      u_if.PciReset = 1'b0;
      tick(5);
      check_all("dbl.frozen", ST_FAILED, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      u_if.Pwr_ok = 1'b0;
      tick(1);
      check_all("dbl.pwroff", ST_IDLE, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      u_if.Pwr_ok = 1'b1;
      tick(1);
      check_all("dbl.pwron", ST_WAIT, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

      // Watchdog disabled: every rise counts as a good boot.
      u_if.WdtEnable = 1'b0;
      u_if.PciReset  = 1'b1;
      tick(1);
      check("nowdt.booted", 32'(u_if.WdtState), 32'(ST_BOOTED));
      u_if.WdtEnable = 1'b1;
      u_if.PciReset  = 1'b0;
      tick(1);

      // BootDone in the timeout cycle wins.
      rq_base = rq_cnt;
      u_if.PciReset = 1'b1;
      tick(1);
      tick(99);
      check("sim.timing", 32'(u_if.WdtState), 32'(ST_TIMING));
      u_if.BootDone = 1'b1;
      tick(1);
      u_if.BootDone = 1'b0;
      check_all("sim.bootdone", ST_BOOTED, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

      // Warm reset in the timeout cycle wins.
      u_if.PciReset = 1'b0;
      tick(1);
      u_if.PciReset = 1'b1;
      tick(1);
      tick(99);
      u_if.PciReset = 1'b0;
      tick(1);
      check_all("sim.fall", ST_WAIT, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      check("sim.no_pulse", 32'(rq_cnt - rq_base), 32'd0);

      // Reset in the second SWITCH cycle cuts the pulse.
      u_if.PciReset = 1'b1;
      tick(1);
      tick(100);
      check_all("rst.switch1", ST_SWITCH, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
      tick(1);
      check("rst.switch2", 32'(u_if.BiosRstReq), 32'd1);
      reset = 1'b1;
      tick(1);
      check_all("rst.cleared", ST_IDLE, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      tick(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
